// File: rtl/citadel_pkg.sv
// Shared types and constants for the citadel authorization controller:
// FSM state encoding, the reference key and default window timings.
package citadel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_GRANT   = 3'd2,
        ST_FAIL    = 3'd3,
        ST_LOCKOUT = 3'd4,
        ST_BRICK   = 3'd5
    } state_t;

    localparam int KEY_NUM = 4;
    localparam logic [7:0] KEY [KEY_NUM] = '{8'hB6, 8'h5A, 8'hC3, 8'h0F};

    localparam int DEF_KEY_LEN      = 4;
    localparam int DEF_MAX_FAIL     = 3;
    localparam int DEF_LOCK_CYCLES  = 1024;
    localparam int DEF_GRANT_CYCLES = 256;

    // Sequences longer than the stored key reuse it cyclically.
    function automatic logic [7:0] key_at(input int unsigned idx);
        logic [1:0] sel;
        sel = 2'(idx % 32'd4);
        return KEY[sel];
    endfunction

endpackage

// File: rtl/citadel_window_timer.sv
// Down-counter shared by the GRANT and LOCKOUT windows; expire is high
// whenever the count rests at zero.
module citadel_window_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] count_r;

    // Clear beats load, load beats decrement; the count holds at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= value;
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (count_r == {W{1'b0}});

endmodule

// File: rtl/citadel_auth_ctrl.sv
// Key-sequence authorization controller with failure lockout and tamper brick.
// All outputs come straight from registers.
module citadel_auth_ctrl
    import citadel_pkg::*;
#(
    parameter int KEY_LEN      = DEF_KEY_LEN,
    parameter int MAX_FAIL     = DEF_MAX_FAIL,
    parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES,
    parameter int GRANT_CYCLES = DEF_GRANT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] key_byte,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic       abort,
    input  logic       tamper,
    output logic [2:0] state_o,
    output logic       unlocked,
    output logic       grant_pulse,
    output logic [1:0] fail_cnt
);

    localparam int WIN_MAX  = (LOCK_CYCLES > GRANT_CYCLES) ? LOCK_CYCLES : GRANT_CYCLES;
    localparam int TMR_W    = (WIN_MAX > 32'sd1) ? $clog2(WIN_MAX) : 32'sd1;
    localparam int IDX_W    = (KEY_LEN > 32'sd2) ? $clog2(KEY_LEN) : 32'sd1;
    localparam int LAST_IDX = KEY_LEN - 32'sd1;

    state_t             state_r;
    logic [IDX_W-1:0]   idx_r;
    logic               match_r;
    logic [1:0]         fail_cnt_r;
    logic               unlocked_r;
    logic               grant_pulse_r;
    logic               key_ready_r;

    logic               accept_s;
    logic               match_upd_s;
    logic               last_s;
    logic [1:0]         fail_inc_s;
    logic               live_s;
    logic               grant_entry_s;
    logic               lock_entry_s;
    logic               tmr_clr_s;
    logic               tmr_load_s;
    logic [TMR_W-1:0]   tmr_value_s;
    logic               tmr_expire_s;

    // Transition decode shared by the sequencer and the window timer.
    always_comb begin
        accept_s      = key_valid && key_ready_r;
        match_upd_s   = match_r && (key_byte == key_at(32'(idx_r)));
        last_s        = (int'(idx_r) == LAST_IDX);
        fail_inc_s    = (fail_cnt_r == 2'd3) ? 2'd3 : (fail_cnt_r + 2'd1);
        live_s        = ena && !tamper;
        grant_entry_s = live_s && (state_r == ST_COLLECT) && !abort
                        && accept_s && last_s && match_upd_s;
        lock_entry_s  = live_s && (state_r == ST_FAIL) && (int'(fail_inc_s) >= MAX_FAIL);
        tmr_load_s    = grant_entry_s || lock_entry_s;
        tmr_value_s   = grant_entry_s ? TMR_W'(GRANT_CYCLES - 32'sd1)
                                      : TMR_W'(LOCK_CYCLES - 32'sd1);
        tmr_clr_s     = !live_s || ((state_r == ST_GRANT) && abort);
    end

    citadel_window_timer #(
        .W(TMR_W)
    ) u_window_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr_s),
        .load   (tmr_load_s),
        .value  (tmr_value_s),
        .expire (tmr_expire_s)
    );

    // Main sequencer: ena-low clear outranks tamper, tamper outranks every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            idx_r         <= {IDX_W{1'b0}};
            match_r       <= 1'b0;
            fail_cnt_r    <= 2'd0;
            unlocked_r    <= 1'b0;
            grant_pulse_r <= 1'b0;
            key_ready_r   <= 1'b0;
        end else if (!ena) begin
            state_r       <= ST_IDLE;
            idx_r         <= {IDX_W{1'b0}};
            match_r       <= 1'b0;
            fail_cnt_r    <= 2'd0;
            unlocked_r    <= 1'b0;
            grant_pulse_r <= 1'b0;
            key_ready_r   <= 1'b0;
        end else if (tamper) begin
            state_r       <= ST_BRICK;
            idx_r         <= {IDX_W{1'b0}};
            match_r       <= 1'b0;
            unlocked_r    <= 1'b0;
            grant_pulse_r <= 1'b0;
            key_ready_r   <= 1'b0;
        end else begin
            grant_pulse_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    key_ready_r <= 1'b1;
                    if (accept_s && !abort) begin
                        state_r <= ST_COLLECT;
                        idx_r   <= IDX_W'(1'b1);
                        match_r <= (key_byte == key_at(32'd0));
                    end
                end
                ST_COLLECT: begin
                    if (abort) begin
                        state_r     <= ST_IDLE;
                        idx_r       <= {IDX_W{1'b0}};
                        match_r     <= 1'b0;
                        key_ready_r <= 1'b1;
                    end else if (accept_s && last_s) begin
                        idx_r       <= {IDX_W{1'b0}};
                        match_r     <= 1'b0;
                        key_ready_r <= 1'b0;
                        if (match_upd_s) begin
                            state_r       <= ST_GRANT;
                            unlocked_r    <= 1'b1;
                            grant_pulse_r <= 1'b1;
                            fail_cnt_r    <= 2'd0;
                        end else begin
                            state_r <= ST_FAIL;
                        end
                    end else if (accept_s) begin
                        idx_r       <= idx_r + IDX_W'(1'b1);
                        match_r     <= match_upd_s;
                        key_ready_r <= 1'b1;
                    end else begin
                        key_ready_r <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (abort || tmr_expire_s) begin
                        state_r     <= ST_IDLE;
                        unlocked_r  <= 1'b0;
                        key_ready_r <= 1'b1;
                    end else begin
                        key_ready_r <= 1'b0;
                    end
                end
                ST_FAIL: begin
                    fail_cnt_r <= fail_inc_s;
                    if (lock_entry_s) begin
                        state_r     <= ST_LOCKOUT;
                        key_ready_r <= 1'b0;
                    end else begin
                        state_r     <= ST_IDLE;
                        key_ready_r <= 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (tmr_expire_s) begin
                        state_r     <= ST_IDLE;
                        fail_cnt_r  <= 2'd0;
                        key_ready_r <= 1'b1;
                    end else begin
                        key_ready_r <= 1'b0;
                    end
                end
                ST_BRICK: begin
                    unlocked_r  <= 1'b0;
                    key_ready_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    idx_r       <= {IDX_W{1'b0}};
                    match_r     <= 1'b0;
                    unlocked_r  <= 1'b0;
                    key_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign state_o     = state_r;
    assign unlocked    = unlocked_r;
    assign grant_pulse = grant_pulse_r;
    assign key_ready   = key_ready_r;
    assign fail_cnt    = fail_cnt_r;

endmodule

// File: tb/tb_citadel_auth_ctrl.sv
// Scenario bench for citadel_auth_ctrl: expected sequence outcomes are queued
// as bytes are driven and compared when the controller reacts.
module tb_citadel_auth_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] key_byte = 8'h00;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic       abort = 1'b0;
    logic       tamper = 1'b0;
    logic [2:0] state_o;
    logic       unlocked;
    logic       grant_pulse;
    logic [1:0] fail_cnt;

    typedef struct {
        logic [2:0] st;
        logic [1:0] fc;
    } exp_t;

    exp_t sb_q[$];
    int   model_fail = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    citadel_auth_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .key_byte    (key_byte),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .abort       (abort),
        .tamper      (tamper),
        .state_o     (state_o),
        .unlocked    (unlocked),
        .grant_pulse (grant_pulse),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one 4-byte sequence; the outcome is predicted from the reference key.
    task automatic send_seq(input logic [31:0] word);
        logic [31:0] w;
        logic        ok;
        exp_t        e;
        w  = word;
        ok = (word == 32'hB65AC30F);
        if (ok) model_fail = 0;
        e.st = ok ? 3'd2 : 3'd3;
        e.fc = 2'(model_fail);
        sb_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (key_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL seq_ready byte %0d: got %b expected 1", i, key_ready);
            end
            key_valid = 1'b1;
            key_byte  = w[31:24];
            w         = w << 8;
            step();
        end
        key_valid = 1'b0;
        e = sb_q.pop_front();
        tests_run++;
        if (state_o !== e.st || fail_cnt !== e.fc) begin
            tests_failed++;
            $display("FAIL seq_outcome: got state %0d fail %0d expected state %0d fail %0d",
                     state_o, fail_cnt, e.st, e.fc);
        end
        if (ok) begin
            tests_run++;
            if (grant_pulse !== 1'b1 || unlocked !== 1'b1) begin
                tests_failed++;
                $display("FAIL grant_entry: got pulse %b unlocked %b expected 1 1", grant_pulse, unlocked);
            end
        end else begin
            model_fail = (model_fail < 3) ? model_fail + 1 : 3;
            e.st = (model_fail >= 3) ? 3'd4 : 3'd0;
            e.fc = 2'(model_fail);
            sb_q.push_back(e);
            step();
            e = sb_q.pop_front();
            tests_run++;
            if (state_o !== e.st || fail_cnt !== e.fc) begin
                tests_failed++;
                $display("FAIL after_fail: got state %0d fail %0d expected state %0d fail %0d",
                         state_o, fail_cnt, e.st, e.fc);
            end
        end
    endtask

    task automatic test_reset();
        step();
        step();
        tests_run++;
        if (state_o !== 3'd0 || unlocked !== 1'b0 || grant_pulse !== 1'b0
            || key_ready !== 1'b0 || fail_cnt !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got st %0d unl %b gp %b rdy %b fc %0d expected all 0",
                     state_o, unlocked, grant_pulse, key_ready, fail_cnt);
        end
        rst_n = 1'b1;
        step();
        tests_run++;
        if (key_ready !== 1'b1 || state_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_release: got rdy %b st %0d expected rdy 1 st 0", key_ready, state_o);
        end
    endtask

    // Full correct sequence: one grant pulse, a 256-cycle unlock window, back to IDLE.
    task automatic test_grant();
        int n;
        int pulses;
        send_seq(32'hB65AC30F);
        n = 0;
        pulses = 0;
        while (unlocked === 1'b1 && n < 1000) begin
            n++;
            if (grant_pulse === 1'b1) pulses++;
            step();
        end
        tests_run++;
        if (n != 256) begin
            tests_failed++;
            $display("FAIL grant_len: got %0d expected 256", n);
        end
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL grant_pulse_cnt: got %0d expected 1", pulses);
        end
        tests_run++;
        if (state_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL grant_exit: got %0d expected 0", state_o);
        end
    endtask

    task automatic test_abort();
        send_seq(32'hB600C30F);
        key_valid = 1'b1;
        key_byte  = 8'hB6;
        step();
        key_byte  = 8'h5A;
        step();
        key_byte  = 8'hC3;
        abort     = 1'b1;
        step();
        key_valid = 1'b0;
        abort     = 1'b0;
        tests_run++;
        if (state_o !== 3'd0 || fail_cnt !== 2'(model_fail)) begin
            tests_failed++;
            $display("FAIL abort_collect: got st %0d fc %0d expected st 0 fc %0d",
                     state_o, fail_cnt, model_fail);
        end
        send_seq(32'hB65AC30F);
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests_run++;
        if (state_o !== 3'd0 || unlocked !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_grant: got st %0d unl %b expected st 0 unl 0", state_o, unlocked);
        end
    endtask

    // Three wrong sequences lock out; key_valid stays high through the lockout.
    task automatic test_lockout();
        int n;
        int ready_seen;
        send_seq(32'hB600C30F);
        send_seq(32'hB600C30F);
        send_seq(32'hB600C30F);
        key_valid  = 1'b1;
        key_byte   = 8'hB6;
        n          = 0;
        ready_seen = 0;
        while (state_o === 3'd4 && n < 3000) begin
            n++;
            if (key_ready !== 1'b0) ready_seen++;
            step();
        end
        key_valid = 1'b0;
        model_fail = 0;
        tests_run++;
        if (n != 1024) begin
            tests_failed++;
            $display("FAIL lockout_len: got %0d expected 1024", n);
        end
        tests_run++;
        if (ready_seen != 0) begin
            tests_failed++;
            $display("FAIL lockout_ready: got %0d ready cycles expected 0", ready_seen);
        end
        tests_run++;
        if (state_o !== 3'd0 || fail_cnt !== 2'd0) begin
            tests_failed++;
            $display("FAIL lockout_exit: got st %0d fc %0d expected st 0 fc 0", state_o, fail_cnt);
        end
    endtask

    task automatic test_tamper();
        key_valid = 1'b1;
        key_byte  = 8'hB6;
        step();
        key_valid = 1'b0;
        tamper    = 1'b1;
        step();
        tamper    = 1'b0;
        tests_run++;
        if (state_o !== 3'd5 || unlocked !== 1'b0 || key_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL tamper_collect: got st %0d unl %b rdy %b expected 5 0 0",
                     state_o, unlocked, key_ready);
        end
        key_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        key_valid = 1'b0;
        tests_run++;
        if (state_o !== 3'd5) begin
            tests_failed++;
            $display("FAIL brick_sticky: got %0d expected 5", state_o);
        end
        ena = 1'b0;
        step();
        ena = 1'b1;
        model_fail = 0;
        tests_run++;
        if (state_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL brick_ena_exit: got %0d expected 0", state_o);
        end
        step();
        send_seq(32'hB65AC30F);
        for (int i = 0; i < 5; i++) step();
        tamper = 1'b1;
        step();
        tests_run++;
        if (state_o !== 3'd5 || unlocked !== 1'b0) begin
            tests_failed++;
            $display("FAIL tamper_grant: got st %0d unl %b expected 5 0", state_o, unlocked);
        end
        ena = 1'b0;
        step();
        tests_run++;
        if (state_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL ena_over_tamper: got %0d expected 0", state_o);
        end
        ena    = 1'b1;
        tamper = 1'b0;
        step();
        tests_run++;
        if (key_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ena_ready: got %b expected 1", key_ready);
        end
    endtask

    task automatic test_reset_mid_grant();
        send_seq(32'hB65AC30F);
        for (int i = 0; i < 100; i++) step();
        tests_run++;
        if (unlocked !== 1'b1 || state_o !== 3'd2) begin
            tests_failed++;
            $display("FAIL grant_cycle100: got unl %b st %0d expected 1 2", unlocked, state_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (unlocked !== 1'b0 || state_o !== 3'd0 || key_ready !== 1'b0 || grant_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got unl %b st %0d rdy %b gp %b expected 0 0 0 0",
                     unlocked, state_o, key_ready, grant_pulse);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_fail = 0;
        step();
        tests_run++;
        if (key_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 1", key_ready);
        end
        test_grant();
    endtask

    initial begin
        test_reset();
        test_grant();
        test_abort();
        test_lockout();
        test_tamper();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/citadel_auth_ctrl.md
CITADEL_AUTH_CTRL -- requirements
Module: citadel_auth_ctrl

Interface
REQ-001 Parameter KEY_LEN, default 4: bytes per authorization sequence.
REQ-002 Parameter MAX_FAIL, default 3: consecutive failed sequences before lockout.
REQ-003 Parameter LOCK_CYCLES, default 1024: lockout duration in clk cycles.
REQ-004 Parameter GRANT_CYCLES, default 256: unlock hold window in clk cycles.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 rst_n  in  1  global reset; one clock; reset asynchronous, active-low.
REQ-007 ena  in  1  power-state enable; low acts as synchronous clear to IDLE.
REQ-008 key_byte  in  8  candidate key byte.
REQ-009 key_valid  in  1  key_byte qualifier; a byte is accepted when key_valid and key_ready are both high.
REQ-010 key_ready  out  1  controller accepts a byte this cycle.
REQ-011 abort  in  1  discard the partial sequence.
REQ-012 tamper  in  1  tamper flag from the perimeter monitor.
REQ-013 state_o  out  3  encoded FSM state.
REQ-014 unlocked  out  1  authorization granted.
REQ-015 grant_pulse  out  1  one-cycle pulse on entry to GRANT.
REQ-016 fail_cnt  out  2  consecutive failure count, saturating at 3.

Function
REQ-017 The FSM SHALL have states IDLE=0, COLLECT=1, GRANT=2, FAIL=3, LOCKOUT=4, BRICK=5, driven on state_o.
REQ-018 key_ready SHALL be high only in IDLE and COLLECT while ena=1.
REQ-019 IDLE: an accepted byte SHALL load index=1, set match = (byte==KEY[0]), and go to COLLECT.
REQ-020 COLLECT:
- Each accepted byte SHALL AND its comparison with KEY[index] into match and increment index.
- On acceptance of byte KEY_LEN-1, the next state SHALL be GRANT if match, else FAIL.
- Comparison is deferred; a wrong early byte SHALL NOT end collection early.
REQ-021 abort in COLLECT SHALL return to IDLE with index/match cleared and fail_cnt unchanged; abort takes priority over a same-cycle accepted byte.
REQ-022 GRANT:
- unlocked=1; fail_cnt cleared on entry.
- A down-counter loaded with GRANT_CYCLES-1 on entry SHALL decrement each cycle, so unlocked is high for exactly GRANT_CYCLES cycles.
- At 0, or on abort, the FSM SHALL return to IDLE.
REQ-023 FAIL (one cycle):
- SHALL increment fail_cnt, saturating at 3.
- Next state SHALL be LOCKOUT if the incremented count >= MAX_FAIL, else IDLE.
REQ-024 LOCKOUT:
- A counter loaded with LOCK_CYCLES-1 on entry SHALL decrement each cycle; abort SHALL be ignored.
- At 0, the FSM SHALL go to IDLE with fail_cnt cleared.
REQ-025 tamper=1 in any state SHALL go to BRICK next cycle, with priority over all other transitions.
REQ-026 BRICK:
- Sticky; exit only via ena=0 or rst_n=0.
- unlocked=0 and key_ready=0.
REQ-027 ena=0 SHALL force IDLE, clearing the counters, index, match and fail_cnt; ena=0 takes priority over tamper.
REQ-028 grant_pulse SHALL be high in exactly the first cycle of GRANT.
REQ-029 All outputs SHALL be registered or decoded from registered state only; there is no combinational path from any input to any output.

Reset
REQ-030 While rst_n=0: state=IDLE, index=0, match=0, counters=0, fail_cnt=0, unlocked=0, grant_pulse=0, key_ready=0.
REQ-031 key_ready SHALL assert in the first cycle after rst_n deasserts if ena=1.
REQ-032 Reset mid-GRANT or mid-LOCKOUT SHALL abandon the window immediately.

Structure
REQ-033 Package citadel_pkg SHALL hold:
- the state enum (3-bit);
- the KEY array constant {8'hB6, 8'h5A, 8'hC3, 8'h0F};
- default timing constants.
REQ-034 The GRANT and LOCKOUT windows SHALL share one down-counter sub-module, citadel_window_timer, with load/value/expire ports.

Verification
REQ-035 Scenario: the bench SHALL send B6,5A,C3,0F on consecutive cycles -> grant_pulse high for 1 cycle, unlocked high for 256 cycles, then state_o=0.
REQ-036 Scenario: the bench SHALL send B6,00,C3,0F three times -> fail_cnt steps 1,2,3, state_o=4 for 1024 cycles, then IDLE with fail_cnt=0.
REQ-037 Scenario: the bench SHALL send B6,5A, then abort on the same cycle as valid C3 -> state_o=0, fail_cnt unchanged, the next full correct sequence grants.
REQ-038 Scenario: the bench SHALL assert tamper mid-COLLECT and mid-GRANT -> state_o=5 next cycle, unlocked=0, key bytes ignored; an ena low pulse returns state_o to 0.
REQ-039 Scenario: the bench SHALL hold key_valid high with key_ready low during LOCKOUT -> no byte consumed and the lockout length is unchanged.
REQ-040 Scenario: the bench SHALL assert rst_n low at cycle 100 of GRANT -> unlocked=0 immediately (asynchronously), state_o=0, counters 0.
